i2s_player: RTL and testbench

I2S_PLAYER -- requirements
Module: i2s_player

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_bclk_gen.sv | 36 +++
 rtl/i2s_player.sv | 70 +++++++
 tb/tb_i2s_player.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S player: frame geometry and default sizing.
package i2s_pkg;

  localparam int FRAME_BITS        = 64;
  localparam int SLOT_BITS         = 32;
  localparam int DEFAULT_DATA_W    = 16;
  localparam int DEFAULT_BCLK_HALF = 4;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // Slot position 0 is the one-bit I2S delay; positions 1..data_w carry sample bits MSB first.
  function automatic logic slot_carries_data(input logic [4:0] pos, input int data_w);
    return (pos != 5'd0) && (int'(pos) <= data_w);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles dac_bclk every BCLK_HALF system clocks and flags the falling-edge cycle.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = DEFAULT_BCLK_HALF
) (
  input  logic clk_12mhz,
  input  logic rst,
  output logic dac_bclk,
  output logic bclk_fall
);

  localparam int CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BCLK_HALF - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = (div_cnt == LAST_CNT);

  // High on the clk edge where the registered dac_bclk is about to go 1->0.
  assign bclk_fall = wrap & dac_bclk;

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      dac_bclk <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      dac_bclk <= ~dac_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_player.sv
// Mono I2S transmitter: latches one sample per 64-bit frame and sends it MSB first in both slots.
// Optional build macro I2S_RIGHT_MUTE_EN silences the right slot while keeping LRCK timing.
module i2s_player
  import i2s_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BCLK_HALF = DEFAULT_BCLK_HALF
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_in,
  output logic              dac_bclk,
  output logic              dac_lrck,
  output logic              dac_din
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int POS_W = $clog2(SLOT_BITS);

  logic              bclk_fall;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  next_bit;
  logic [POS_W-1:0]  next_pos;
  logic [DATA_W-1:0] latched_sample;
  logic [DATA_W-1:0] shifted;
  logic              next_din;

  i2s_bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk (
    .clk_12mhz(clk_12mhz),
    .rst      (rst),
    .dac_bclk (dac_bclk),
    .bclk_fall(bclk_fall)
  );

  assign next_bit = bit_cnt + 1'b1;
  assign next_pos = next_bit[POS_W-1:0];

  // Outputs are computed for the bit position being entered, so every output is a plain register.
  always_comb begin
    next_din = 1'b0;
    shifted  = latched_sample << (next_pos - 1'b1);
    if (slot_carries_data(next_pos, DATA_W)) begin
      next_din = shifted[DATA_W-1];
    end
`ifdef I2S_RIGHT_MUTE_EN
    if (next_bit[BIT_W-1]) begin
      next_din = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      bit_cnt        <= '0;
      dac_lrck       <= SLOT_LEFT;
      dac_din        <= 1'b0;
      latched_sample <= '0;
    end else if (bclk_fall) begin
      bit_cnt  <= next_bit;
      dac_lrck <= next_bit[BIT_W-1] ? SLOT_RIGHT : SLOT_LEFT;
      dac_din  <= next_din;
      if (next_bit == '0) begin
        latched_sample <= audio_in;
      end
    end
  end

endmodule

// File: tb/tb_i2s_player.sv
// Randomized bench for i2s_player against a cycle-count reference model; honours I2S_RIGHT_MUTE_EN.
`timescale 1ns/1ps
module tb_i2s_player;

  localparam int DATA_W     = 16;
  localparam int HALF       = 4;
  localparam int PERIOD     = 2 * HALF;
  localparam int FRAME_CYC  = 64 * PERIOD;

  logic              clk_12mhz = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] audio_in;
  logic              dac_bclk;
  logic              dac_lrck;
  logic              dac_din;

  int n_checks = 0;
  int n_passed = 0;

  // Model state: clk edges since reset release, BCLK falls seen, sample of the current frame.
  int                edges;
  int                falls;
  logic [DATA_W-1:0] exp_latched;

  i2s_player #(
    .DATA_W   (DATA_W),
    .BCLK_HALF(HALF)
  ) dut (
    .clk_12mhz(clk_12mhz),
    .rst      (rst),
    .audio_in (audio_in),
    .dac_bclk (dac_bclk),
    .dac_lrck (dac_lrck),
    .dac_din  (dac_din)
  );

  always #42 clk_12mhz = ~clk_12mhz;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic model_din(input int b, input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] t;
    int p;
    p = b % 32;
`ifdef I2S_RIGHT_MUTE_EN
    if (b >= 32) return 1'b0;
`endif
    if (p < 1 || p > DATA_W) return 1'b0;
    t = s >> (DATA_W - p);
    return t[0];
  endfunction

  task automatic checkModel();
    int b;
    b = falls % 64;
    checkOutput("bclk",    32'(dac_bclk),           32'((edges / HALF) % 2));
    checkOutput("bit_cnt", 32'(dut.bit_cnt),        32'(b));
    checkOutput("lrck",    32'(dac_lrck),           32'(b >= 32));
    checkOutput("din",     32'(dac_din),            32'(model_din(b, exp_latched)));
    checkOutput("latched", 32'(dut.latched_sample), 32'(exp_latched));
  endtask

  // One clk cycle: advance the model at the rising edge, check at the falling edge, then drive.
  task automatic applyStimulus(input bit rnd);
    @(posedge clk_12mhz);
    edges++;
    if (edges % PERIOD == 0) begin
      falls++;
      if (falls % 64 == 0) exp_latched = audio_in;
    end
    @(negedge clk_12mhz);
    checkModel();
    if (rnd) audio_in = DATA_W'($urandom);
  endtask

  task automatic runToBit(input int target, input bit rnd);
    int guard;
    guard = 0;
    do begin
      applyStimulus(rnd);
      guard++;
    end while (!((edges % PERIOD == 0) && (falls % 64 == target)) && guard < 2 * FRAME_CYC + PERIOD);
    checkOutput($sformatf("reach_bit_%0d", target), 32'(dut.bit_cnt), 32'(target));
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_bclk",    32'(dac_bclk),              0);
    checkOutput("rst_lrck",    32'(dac_lrck),              0);
    checkOutput("rst_din",     32'(dac_din),               0);
    checkOutput("rst_bit_cnt", 32'(dut.bit_cnt),           0);
    checkOutput("rst_latched", 32'(dut.latched_sample),    0);
    checkOutput("rst_div_cnt", 32'(dut.u_bclk.div_cnt),    0);
    repeat (3) @(negedge clk_12mhz);
    rst         = 1'b0;
    edges       = 0;
    falls       = 0;
    exp_latched = '0;
  endtask

  initial begin
    logic right_exp;
`ifdef I2S_RIGHT_MUTE_EN
    right_exp = 1'b0;
`else
    right_exp = 1'b1;
`endif
    audio_in = '0;
    applyReset();

    repeat (3 * FRAME_CYC) applyStimulus(1'b1);

    // MSB-only sample, then an input change mid-frame that must wait for the next latch.
    runToBit(60, 1'b0);
    audio_in = 16'h8000;
    runToBit(0, 1'b0);
    checkOutput("msb1_bit0", 32'(dac_din), 0);
    checkOutput("msb1_latched", 32'(dut.latched_sample), 32'h8000);
    runToBit(1, 1'b0);
    checkOutput("msb1_bit1", 32'(dac_din), 1);
    runToBit(2, 1'b0);
    checkOutput("msb1_bit2", 32'(dac_din), 0);
    runToBit(10, 1'b0);
    audio_in = 16'h7FFF;
    runToBit(16, 1'b0);
    checkOutput("hold_bit16", 32'(dac_din), 0);
    runToBit(33, 1'b0);
    checkOutput("msb1_bit33", 32'(dac_din), 32'(right_exp));
    checkOutput("hold_latched", 32'(dut.latched_sample), 32'h8000);

    runToBit(1, 1'b0);
    checkOutput("msb0_bit1", 32'(dac_din), 0);
    checkOutput("msb0_latched", 32'(dut.latched_sample), 32'h7FFF);
    runToBit(2, 1'b0);
    checkOutput("msb0_bit2", 32'(dac_din), 1);
    runToBit(17, 1'b0);
    checkOutput("msb0_bit17", 32'(dac_din), 0);
    runToBit(34, 1'b0);
    checkOutput("msb0_bit34", 32'(dac_din), 32'(right_exp));
    checkOutput("msb0_lrck34", 32'(dac_lrck), 1);

    // Mid-frame reset with BCLK high and a data bit on the line.
    runToBit(40, 1'b0);
    repeat (HALF + 1) applyStimulus(1'b0);
    applyReset();

    repeat (2 * FRAME_CYC) applyStimulus(1'b1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
